operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch (ID/EX) stage that sits between instruction decode and the ALU stage and drives the read side of the register file. It presents source register addresses to the register file, captures the returned operands into a valid/ready pipeline register, and keeps a per-register pending-write scoreboard so that no instruction issues with a stale operand. It also bypasses same-cycle write-back data, because the register file reads asynchronously and only commits writes on the clock edge.

## Interface
- DATA_W, 32, operand/data width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inValid  in  1  decode offers an instruction
- inReady  out  1  stage accepts the instruction this cycle
- inRs, inRt  in  ADDR_W  source register addresses
- inRd  in  ADDR_W  destination register address
- inWritesReg  in  1  instruction writes inRd
- addrA, addrB  out  ADDR_W  to register file read ports
- dataOutA, dataOutB  in  DATA_W  from register file read ports
- wbEnable, wbAddr, wbData  in  1/ADDR_W/DATA_W  copy of the register-file write port, observed only
- flush  in  1  kill the instruction held in the output register
- outValid  out  1  operands valid for the ALU stage
- outReady  in  1  ALU stage accepts
- outA, outB  out  DATA_W  captured operands
- outRd  out  ADDR_W, outWritesReg  out  1  destination passed downstream
- stallCount  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- addrA = inRs, addrB = inRt, combinational and unconditional.
- Scoreboard: pending[0..2^ADDR_W-1], one bit per register; pending[0] is always 0.
- Operand selection for source s (A or B): 0 if its address is 0; else wbData if wbEnable && wbAddr == address; else the register-file data.
- clr(r) = wbEnable && wbAddr == r. A register is blocked if r != 0 && pending[r] && !clr(r).
- hazard = blocked(inRs) || blocked(inRt) || (inWritesReg && blocked(inRd)). A blocked inRd is a WAW stall.
- inReady = !flush && !hazard && (!outValid || outReady). inReady does not depend on inValid.
- Accept = inValid && inReady. On accept: the output register loads the selected operands, inRd and inWritesReg; outValid becomes 1. If inWritesReg && inRd != 0, pending[inRd] is set.
- If outValid && outReady && !accept: outValid becomes 0.
- Pending update per register: set has priority over clear in the same cycle.
- Flush: outValid becomes 0. If outValid && outWritesReg held, pending[outRd] is cleared; this clear has priority over a set. No accept occurs in a flush cycle.
- stallCount increments when inValid && hazard && !flush, and saturates at all-ones.

## Timing
- Reset (async) state: outValid=0, outA=0, outB=0, outRd=0, outWritesReg=0, all pending=0, stallCount=0.
- Reset mid-operation drops any held instruction and all pending bits.
- Latency is one cycle from accept to outValid. Throughput is one instruction per cycle when there is no hazard and outReady is high.
- Output fields are stable while outValid && !outReady.
- A write-back to register X in cycle N unblocks a consumer of X in cycle N, and that consumer receives wbData.

## Test plan
- Reset, then issue rs=1, rt=2 with the register file returning 5/7 and outReady=1 -> next cycle outValid=1, outA=5, outB=7. stallCount=0.
- Issue rd=3 with writes, then an instruction reading rs=3 -> inReady=0 and stallCount increments each cycle. When wbEnable with wbAddr=3 and wbData=0xDEAD arrives, the consumer is accepted that cycle and next cycle outA=0xDEAD.
- rs=0, rt=0, with the register file driving 0xFFFF_FFFF and a pending write to r0 attempted -> outA=outB=0, pending[0] stays 0, no stall.
- Hold outReady=0 with outValid=1 while inValid=1 -> inReady=0 and outputs unchanged. Raising outReady accepts the next instruction in that same cycle.
- Issue rd=4 with writes, then assert flush while it is held with outReady=0 -> outValid=0 and pending[4]=0. A following reader of r4 issues without stall.
- Force 2^CNT_W+3 hazard cycles -> stallCount holds at all-ones, then async rst mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Bundle of the operand-fetch stage's pipeline, register-file and write-back signals.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface operand_fetch_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              inValid;
   logic              inReady;
   logic [ADDR_W-1:0] inRs;
   logic [ADDR_W-1:0] inRt;
   logic [ADDR_W-1:0] inRd;
   logic              inWritesReg;

   logic [ADDR_W-1:0] addrA;
   logic [ADDR_W-1:0] addrB;
   logic [DATA_W-1:0] dataOutA;
   logic [DATA_W-1:0] dataOutB;

   logic              wbEnable;
   logic [ADDR_W-1:0] wbAddr;
   logic [DATA_W-1:0] wbData;

   logic              flush;
   logic              outValid;
   logic              outReady;
   logic [DATA_W-1:0] outA;
   logic [DATA_W-1:0] outB;
   logic [ADDR_W-1:0] outRd;
   logic              outWritesReg;

   modport master (
      output inValid, inRs, inRt, inRd, inWritesReg,
      output dataOutA, dataOutB,
      output wbEnable, wbAddr, wbData,
      output flush, outReady,
      input  inReady, addrA, addrB,
      input  outValid, outA, outB, outRd, outWritesReg
   );

   modport slave (
      input  inValid, inRs, inRt, inRd, inWritesReg,
      input  dataOutA, dataOutB,
      input  wbEnable, wbAddr, wbData,
      input  flush, outReady,
      output inReady, addrA, addrB,
      output outValid, outA, outB, outRd, outWritesReg
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register-file read, write-back bypass, pending-write
// scoreboard for RAW/WAW stalls, and a valid/ready output register.
module operand_fetch #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   operand_fetch_if.slave     bus,
   output logic [CNT_W-1:0]   stallCount
);
   localparam int unsigned NREG = 1 << ADDR_W;

   logic [NREG-1:0]   pending;
   logic [NREG-1:0]   pending_nxt;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic              hazard;
   logic              accept;
   logic              set_en;
   logic              kill;

   // A register is blocked while a write is outstanding and not landing this cycle.
   function automatic logic blocked(input logic [ADDR_W-1:0] r,
                                    input logic [NREG-1:0]   pend,
                                    input logic              wb_en,
                                    input logic [ADDR_W-1:0] wb_addr);
      return (r != '0) && pend[r] && !(wb_en && (wb_addr == r));
   endfunction

   assign bus.addrA = bus.inRs;
   assign bus.addrB = bus.inRt;

   // Operand select: r0 reads zero, same-cycle write-back overrides the register file.
   always_comb begin
      sel_a = bus.dataOutA;
      sel_b = bus.dataOutB;
      if (bus.wbEnable && (bus.wbAddr == bus.inRs)) sel_a = bus.wbData;
      if (bus.wbEnable && (bus.wbAddr == bus.inRt)) sel_b = bus.wbData;
      if (bus.inRs == '0) sel_a = '0;
      if (bus.inRt == '0) sel_b = '0;
   end

   always_comb begin
      hazard = blocked(bus.inRs, pending, bus.wbEnable, bus.wbAddr)
            || blocked(bus.inRt, pending, bus.wbEnable, bus.wbAddr)
            || (bus.inWritesReg && blocked(bus.inRd, pending, bus.wbEnable, bus.wbAddr));
   end

   assign bus.inReady = !bus.flush && !hazard && (!bus.outValid || bus.outReady);
   assign accept      = bus.inValid && bus.inReady;
   assign set_en      = accept && bus.inWritesReg;
   assign kill        = bus.flush && bus.outValid && bus.outWritesReg;

   // Scoreboard update: write-back clears, issue sets over it, flush clears over everything.
   always_comb begin
      pending_nxt = pending;
      for (int unsigned r = 1; r < NREG; r++) begin
         if (bus.wbEnable && (bus.wbAddr == ADDR_W'(r))) pending_nxt[r] = 1'b0;
         if (set_en && (bus.inRd == ADDR_W'(r)))         pending_nxt[r] = 1'b1;
         if (kill && (bus.outRd == ADDR_W'(r)))          pending_nxt[r] = 1'b0;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.outValid     <= 1'b0;
         bus.outA         <= '0;
         bus.outB         <= '0;
         bus.outRd        <= '0;
         bus.outWritesReg <= 1'b0;
      end else if (bus.flush) begin
         bus.outValid     <= 1'b0;
      end else if (accept) begin
         bus.outValid     <= 1'b1;
         bus.outA         <= sel_a;
         bus.outB         <= sel_b;
         bus.outRd        <= bus.inRd;
         bus.outWritesReg <= bus.inWritesReg;
      end else if (bus.outValid && bus.outReady) begin
         bus.outValid     <= 1'b0;
      end
   end

   // Saturating count of cycles an offered instruction is held back by a hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCount <= '0;
      end else if (bus.inValid && hazard && !bus.flush && (stallCount != '1)) begin
         stallCount <= stallCount + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: bypass, RAW/WAW stalls, r0, backpressure,
// flush, counter saturation and asynchronous reset.
module tb_operand_fetch;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 16;

   logic             clk;
   logic             rst;
   logic [CNT_W-1:0] stallCount;
   int               n_assert;
   int               n_fail;

   operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .stallCount (stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic wr, input logic [31:0] da, input logic [31:0] db);
      bus.inValid     = 1'b1;
      bus.inRs        = rs;
      bus.inRt        = rt;
      bus.inRd        = rd;
      bus.inWritesReg = wr;
      bus.dataOutA    = da;
      bus.dataOutB    = db;
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst              = 1'b1;
      bus.inValid      = 1'b0;
      bus.inRs         = '0;
      bus.inRt         = '0;
      bus.inRd         = '0;
      bus.inWritesReg  = 1'b0;
      bus.dataOutA     = '0;
      bus.dataOutB     = '0;
      bus.wbEnable     = 1'b0;
      bus.wbAddr       = '0;
      bus.wbData       = '0;
      bus.flush        = 1'b0;
      bus.outReady     = 1'b1;
      tick();
      tick();
      chk("rst_outValid", 64'(bus.outValid), 64'd0);
      chk("rst_outA", 64'(bus.outA), 64'd0);
      chk("rst_outB", 64'(bus.outB), 64'd0);
      chk("rst_outRd", 64'(bus.outRd), 64'd0);
      chk("rst_outWr", 64'(bus.outWritesReg), 64'd0);
      chk("rst_stall", 64'(stallCount), 64'd0);
      rst = 1'b0;
      tick();

      // Basic issue rs=1, rt=2
      offer(5'd1, 5'd2, 5'd0, 1'b0, 32'd5, 32'd7);
      chk("addrA", 64'(bus.addrA), 64'd1);
      chk("addrB", 64'(bus.addrB), 64'd2);
      chk("basic_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("basic_valid", 64'(bus.outValid), 64'd1);
      chk("basic_A", 64'(bus.outA), 64'd5);
      chk("basic_B", 64'(bus.outB), 64'd7);
      chk("basic_stall", 64'(stallCount), 64'd0);

      // RAW on r3 resolved by same-cycle write-back bypass
      offer(5'd0, 5'd0, 5'd3, 1'b1, 32'd0, 32'd0);
      tick();
      chk("prod_rd", 64'(bus.outRd), 64'd3);
      chk("prod_wr", 64'(bus.outWritesReg), 64'd1);
      offer(5'd3, 5'd0, 5'd0, 1'b0, 32'h1234, 32'd0);
      chk("raw_ready0", 64'(bus.inReady), 64'd0);
      tick();
      chk("raw_stall1", 64'(stallCount), 64'd1);
      chk("raw_drained", 64'(bus.outValid), 64'd0);
      tick();
      chk("raw_stall2", 64'(stallCount), 64'd2);
      bus.wbEnable = 1'b1;
      bus.wbAddr   = 5'd3;
      bus.wbData   = 32'h0000_DEAD;
      #1;
      chk("raw_wb_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("raw_bypass_A", 64'(bus.outA), 64'h0000_DEAD);
      chk("raw_stall_hold", 64'(stallCount), 64'd2);
      bus.wbEnable = 1'b0;
      offer(5'd3, 5'd0, 5'd0, 1'b0, 32'h1111, 32'd0);
      chk("r3_cleared_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("r3_regfile_A", 64'(bus.outA), 64'h1111);

      // r0 reads zero and is never marked pending
      offer(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      chk("r0_A", 64'(bus.outA), 64'd0);
      chk("r0_B", 64'(bus.outB), 64'd0);
      bus.wbEnable = 1'b1;
      bus.wbAddr   = 5'd0;
      bus.wbData   = 32'h0000_0ABC;
      offer(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("r0_no_waw", 64'(bus.inReady), 64'd1);
      tick();
      chk("r0_wb_A", 64'(bus.outA), 64'd0);
      chk("r0_stall", 64'(stallCount), 64'd2);
      bus.wbEnable = 1'b0;

      // Backpressure holds the output register
      offer(5'd5, 5'd6, 5'd0, 1'b0, 32'h55, 32'h66);
      tick();
      chk("bp_A", 64'(bus.outA), 64'h55);
      bus.outReady = 1'b0;
      offer(5'd7, 5'd0, 5'd0, 1'b0, 32'h77, 32'd0);
      chk("bp_ready0", 64'(bus.inReady), 64'd0);
      tick();
      tick();
      chk("bp_hold_valid", 64'(bus.outValid), 64'd1);
      chk("bp_hold_A", 64'(bus.outA), 64'h55);
      chk("bp_hold_B", 64'(bus.outB), 64'h66);
      chk("bp_no_stall", 64'(stallCount), 64'd2);
      bus.outReady = 1'b1;
      #1;
      chk("bp_release_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("bp_next_A", 64'(bus.outA), 64'h77);

      // Flush kills a held writer of r4 and releases its scoreboard bit
      offer(5'd0, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0);
      tick();
      bus.outReady = 1'b0;
      bus.inValid  = 1'b0;
      tick();
      chk("fl_held", 64'(bus.outRd), 64'd4);
      bus.flush = 1'b1;
      offer(5'd4, 5'd0, 5'd0, 1'b0, 32'h4444, 32'd0);
      chk("fl_ready0", 64'(bus.inReady), 64'd0);
      tick();
      chk("fl_valid0", 64'(bus.outValid), 64'd0);
      chk("fl_no_stall", 64'(stallCount), 64'd2);
      bus.flush    = 1'b0;
      bus.outReady = 1'b1;
      #1;
      chk("fl_reader_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("fl_reader_A", 64'(bus.outA), 64'h4444);

      // WAW on r8; write-back and re-issue in the same cycle keep r8 pending
      offer(5'd0, 5'd0, 5'd8, 1'b1, 32'd0, 32'd0);
      tick();
      offer(5'd9, 5'd0, 5'd8, 1'b1, 32'h9999, 32'd0);
      chk("waw_ready0", 64'(bus.inReady), 64'd0);
      tick();
      chk("waw_stall", 64'(stallCount), 64'd3);
      bus.wbEnable = 1'b1;
      bus.wbAddr   = 5'd8;
      bus.wbData   = 32'h0000_BEEF;
      #1;
      chk("waw_wb_ready", 64'(bus.inReady), 64'd1);
      tick();
      chk("waw_A", 64'(bus.outA), 64'h9999);
      chk("waw_rd", 64'(bus.outRd), 64'd8);
      bus.wbEnable = 1'b0;
      bus.outReady = 1'b0;
      offer(5'd8, 5'd0, 5'd0, 1'b0, 32'h8888, 32'd0);
      chk("set_over_clr_ready0", 64'(bus.inReady), 64'd0);

      // Saturate the stall counter, then reset asynchronously mid-stall
      for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
      chk("sat_count", 64'(stallCount), 64'hFFFF);
      chk("sat_held_valid", 64'(bus.outValid), 64'd1);
      chk("sat_held_A", 64'(bus.outA), 64'h9999);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(bus.outValid), 64'd0);
      chk("arst_A", 64'(bus.outA), 64'd0);
      chk("arst_B", 64'(bus.outB), 64'd0);
      chk("arst_rd", 64'(bus.outRd), 64'd0);
      chk("arst_wr", 64'(bus.outWritesReg), 64'd0);
      chk("arst_stall", 64'(stallCount), 64'd0);
      chk("arst_pending_clear", 64'(bus.inReady), 64'd1);
      tick();
      rst = 1'b0;
      bus.outReady = 1'b1;
      tick();
      chk("post_rst_A", 64'(bus.outA), 64'h8888);
      chk("post_rst_stall", 64'(stallCount), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
